// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data-memory responder: request control bits,
// responder FSM states and a small alignment helper.
package mem_pkg;

    typedef logic [1:0] mem_ctrl_t;

    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } dmem_state_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/mem_dmem_resp_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface mem_dmem_resp_if;
    import mem_pkg::*;

    logic [31:0] i_memAddr;
    logic [31:0] i_writeData;
    logic [3:0]  i_byteEn;
    mem_ctrl_t   i_ctrlMEM;
    logic [31:0] o_readData;
    logic        o_rvalid;
    logic        o_busy;
    logic        o_err;

    modport master (
        output i_memAddr, i_writeData, i_byteEn, i_ctrlMEM,
        input  o_readData, o_rvalid, o_busy, o_err
    );

    modport slave (
        input  i_memAddr, i_writeData, i_byteEn, i_ctrlMEM,
        output o_readData, o_rvalid, o_busy, o_err
    );

endinterface

// File: rtl/mem_bram_sp.sv
// Single-port 32-bit RAM with four byte-write lanes and a one-cycle registered read.
// A read that coincides with a write returns the freshly written lanes.
module mem_bram_sp #(
    parameter int DEPTH_WORDS = 8192,
    parameter int IDX_W       = $clog2(DEPTH_WORDS),
    parameter     INIT_FILE   = ""
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             rd_en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (we[lane]) begin
                mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
            end
        end
    end

    // Output register only resets, so the array itself still maps to block RAM.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] byte_reg;
        always_ff @(posedge clk) begin
            if (srst) begin
                byte_reg <= '0;
            end else if (rd_en) begin
                byte_reg <= we[gi] ? wdata[8*gi +: 8] : mem[addr][8*gi +: 8];
            end
        end
        assign rdata[8*gi +: 8] = byte_reg;
    end

endmodule

// File: rtl/mem_dmem_resp.sv
// MEM-stage data-memory responder: alignment check, write commit, read FSM with
// configurable latency and a stall (o_busy) while a read is in flight.
module mem_dmem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 8192,
    parameter int READ_LATENCY = 2,
    parameter     INIT_FILE    = ""
) (
    input  logic             i_clk,
    input  logic             i_reset,
    mem_dmem_resp_if.slave   bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam int         PIPE_N   = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "mem_dmem_resp: READ_LATENCY must be 1..4");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $fatal(1, "mem_dmem_resp: DEPTH_WORDS must be a power of 2");
    end

    dmem_state_t          state_reg;
    logic [2:0]           cnt_reg;
    logic                 rvalid_reg;
    logic                 busy_reg;
    logic                 err_reg;
    logic                 req;
    logic                 aligned;
    logic                 rd_en;
    logic [3:0]           we;
    logic [IDX_W-1:0]     idx;
    logic                 last_wait;
    logic [31:0]          ram_q;
    logic [PIPE_N-1:0][31:0] pipe;
    logic                 unused_addr;

    assign req       = (state_reg == IDLE) && (bus.i_ctrlMEM != 2'b00);
    assign aligned   = is_word_aligned(bus.i_memAddr[1:0]);
    assign rd_en     = req && aligned && bus.i_ctrlMEM[MEM_RD];
    assign we        = (req && aligned && bus.i_ctrlMEM[MEM_WR]) ? bus.i_byteEn : 4'b0000;
    assign idx       = bus.i_memAddr[IDX_W+1:2];
    assign last_wait = (state_reg == RD_WAIT) && (cnt_reg == 3'd1);
    // Address bits above the RAM index simply alias onto the same words.
    assign unused_addr = ^bus.i_memAddr[31:IDX_W+2];

    mem_bram_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (i_clk),
        .srst  (i_reset),
        .rd_en (rd_en),
        .we    (we),
        .addr  (idx),
        .wdata (bus.i_writeData),
        .rdata (ram_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            rvalid_reg <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req && !aligned) begin
                        err_reg <= 1'b1;
                    end else if (rd_en) begin
                        if (READ_LATENCY == 1) begin
                            rvalid_reg <= 1'b1;
                        end else begin
                            state_reg <= RD_WAIT;
                            cnt_reg   <= CNT_INIT;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (last_wait) begin
                        rvalid_reg <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // RAM output plus READ_LATENCY-2 delay stages; the RAM holds its output while busy.
    assign pipe[0] = ram_q;
    genvar gi;
    for (gi = 1; gi < PIPE_N; gi++) begin : g_stage
        logic [31:0] stage_reg;
        always_ff @(posedge i_clk) begin
            stage_reg <= pipe[gi-1];
        end
        assign pipe[gi] = stage_reg;
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign bus.o_readData = pipe[0];
    end else begin : g_latn
        logic [31:0] rdata_reg;
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                rdata_reg <= '0;
            end else if (last_wait) begin
                rdata_reg <= pipe[PIPE_N-1];
            end
        end
        assign bus.o_readData = rdata_reg;
    end

    assign bus.o_rvalid = rvalid_reg;
    assign bus.o_busy   = busy_reg;
    assign bus.o_err    = err_reg;

endmodule
